// File: rtl/mac_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mac_sequencer_if
// Brief    : Command, operand stream and result stream bundle for mac_sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
interface mac_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) ();
  localparam int ACC_W = 2*DATA_W + LEN_W;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] bias;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;

  modport master (
    output start, len, bias, in_valid, a, b, out_ready,
    input  busy, in_ready, out_valid, result
  );

  modport slave (
    input  start, len, bias, in_valid, a, b, out_ready,
    output busy, in_ready, out_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mac_sequencer
// Brief    : Sequences an unsigned two-stage multiply-add over a vector onto a bias.
// Revision : 1.0
//------------------------------------------------------------------------------
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mac_sequencer_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + LEN_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_v1;
  logic [ACC_W-1:0]    r_acc;

  logic                w_start;
  logic                w_len_zero;
  logic                w_accept;
  logic                w_last;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_bias_ext;

  assign w_start    = (r_state == S_IDLE) && bus.start;
  assign w_len_zero = (bus.len == '0);
  assign w_accept   = (r_state == S_RUN) && bus.in_valid;
  assign w_last     = w_accept && (r_count == (r_len - LEN_W'(1)));
  assign w_prod     = r_a * r_b;
  assign w_prod_ext = {{LEN_W{1'b0}}, w_prod};
  assign w_bias_ext = {{(ACC_W-DATA_W){1'b0}}, bus.bias};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_len_zero ? S_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage 1 registers the accepted pair; stage 2 folds the previous product into acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_v1    <= 1'b0;
      r_acc   <= '0;
    end else begin
      if (w_start) begin
        r_acc   <= w_bias_ext;
        r_count <= '0;
        if (!w_len_zero) begin
          r_len <= bus.len;
        end
      end else if (r_v1) begin
        r_acc <= r_acc + w_prod_ext;
      end

      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_count <= r_count + LEN_W'(1);
      end
      r_v1 <= w_accept;
    end
  end

  assign bus.in_ready  = (r_state == S_RUN);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mac_sequencer
// Brief    : Randomized and directed scoreboard bench for mac_sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_mac_sequencer;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int AW = 2*DW + LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_sequencer_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  mac_sequencer #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     total = 0;
  int     bad   = 0;
  longint sb[$];
  int     opa[$];
  int     opb[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bias plus the plain dot product of the operand lists.
  function automatic longint model(input int bias, input int n);
    longint s = longint'(bias);
    for (int i = 0; i < n; i++) s += longint'(opa[i]) * longint'(opb[i]);
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: result %0d with nothing expected", bus.result);
      end else begin
        check("sb_result", longint'(bus.result), sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gmode: 0 = back-to-back, 1 = random gaps, 2 = pattern pat[0..patlen-1] then valid.
  task automatic run_op(input int n, input int bias, input int gmode,
                        input bit [31:0] pat, input int patlen, input int hold,
                        input bit start_in_hold, input bit start_at_ack);
    longint exp;
    int     idx, cyc, pi, rdy_cyc;
    bit     v, acc_now;
    exp = model(bias, n);
    sb.push_back(exp);
    bus.start = 1'b1;
    bus.len   = LW'(n);
    bus.bias  = DW'(bias);
    tick();
    bus.start = 1'b0;
    check("busy_after_start", longint'(bus.busy), 1);
    if (n == 0) begin
      check("zero_len_out_valid", longint'(bus.out_valid), 1);
      check("zero_len_in_ready", longint'(bus.in_ready), 0);
    end else begin
      idx = 0; cyc = 0; pi = 0; rdy_cyc = 0;
      while (idx < n && cyc < 4*n + 40) begin
        if (gmode == 0)      v = 1'b1;
        else if (gmode == 1) v = ($urandom_range(0, 3) != 0);
        else                 v = (pi < patlen) ? pat[pi] : 1'b1;
        pi++;
        bus.in_valid = v;
        bus.a = v ? DW'(opa[idx]) : DW'($urandom);
        bus.b = v ? DW'(opb[idx]) : DW'($urandom);
        acc_now = v && bus.in_ready;
        if (bus.in_ready) rdy_cyc++;
        tick();
        cyc++;
        if (acc_now) idx++;
      end
      bus.in_valid = 1'b0;
      if (idx < n) check("beat_timeout", longint'(idx), longint'(n));
      check("in_ready_held", longint'(rdy_cyc), longint'(cyc));
      check("in_ready_low_after_last", longint'(bus.in_ready), 0);
      check("no_early_out_valid", longint'(bus.out_valid), 0);
      tick();
      check("out_valid_latency", longint'(bus.out_valid), 1);
    end
    for (int h = 0; h < hold; h++) begin
      bus.start = start_in_hold && (h == 1);
      bus.len   = LW'(3);
      check("hold_out_valid", longint'(bus.out_valid), 1);
      check("hold_result", longint'(bus.result), exp);
      tick();
    end
    bus.start = 1'b0;
    check("pre_ack_out_valid", longint'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    bus.start     = start_at_ack;
    bus.len       = LW'(1);
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("ack_busy", longint'(bus.busy), 0);
    check("ack_out_valid", longint'(bus.out_valid), 0);
    check("result_kept", longint'(bus.result), exp);
  endtask

  task automatic fill(input int n, input int av, input int bv, input bit rnd);
    opa.delete();
    opb.delete();
    for (int i = 0; i < n; i++) begin
      opa.push_back(rnd ? int'($urandom_range(0, 255)) : av);
      opb.push_back(rnd ? int'($urandom_range(0, 255)) : bv);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_result", longint'(bus.result), 0);
    rst = 1'b0;
    tick();

    opa = '{1, 2, 3}; opb = '{4, 5, 6};
    run_op(3, 10, 0, 32'h0, 0, 1, 1'b0, 1'b0);
    tick();

    opa.delete(); opb.delete();
    run_op(0, 7, 0, 32'h0, 0, 1, 1'b0, 1'b0);
    tick();

    fill(4, 3, 3, 1'b0);
    run_op(4, 0, 2, 32'b1011001, 7, 5, 1'b1, 1'b0);
    tick();

    fill(255, 255, 255, 1'b0);
    run_op(255, 255, 0, 32'h0, 0, 1, 1'b0, 1'b0);
    tick();

    // Abort an operation after two accepted beats.
    fill(5, 9, 9, 1'b0);
    bus.start = 1'b1; bus.len = LW'(5); bus.bias = DW'(9);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.a = DW'(9); bus.b = DW'(9);
      tick();
    end
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", longint'(bus.in_ready), 0);
    check("async_rst_out_valid", longint'(bus.out_valid), 0);
    check("async_rst_busy", longint'(bus.busy), 0);
    check("async_rst_result", longint'(bus.result), 0);
    bus.in_valid = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    opa = '{2, 1}; opb = '{2, 1};
    run_op(2, 1, 0, 32'h0, 0, 0, 1'b0, 1'b0);
    tick();

    fill(6, 0, 0, 1'b1);
    run_op(6, 200, 0, 32'h0, 0, 0, 1'b0, 1'b1);
    fill(5, 0, 0, 1'b1);
    run_op(5, 17, 1, 32'h0, 0, 2, 1'b0, 1'b0);
    tick();

    for (int k = 0; k < 10; k++) begin
      n = int'($urandom_range(0, 20));
      fill(n, 0, 0, 1'b1);
      run_op(n, int'($urandom_range(0, 255)), 1, 32'h0, 0,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    check("sb_empty", longint'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
